// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running video timing generator with vreset resync
//
// Generates hs/vs/de and pixel/line counters for the scaler/encoder. A one-clk
// vreset pulse from the video analyzer snaps the counters to the upper-left
// active pixel (0,0) at the next enabled clock. All outputs are registered.
//
// Optional feature macro: VTG_RESYNC_CNT_EN (adds resync_cnt output).
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ce           pixel clock enable; counters advance only when 1
//   vreset       single-clk resync request, independent of ce
//   hs, vs       syncs, active level HS_POL / VS_POL
//   de           display enable (active area)
//   hcnt, vcnt   current pixel / line
//   frame_start  one-clk pulse when counters become (0,0)
//   resync_cnt   saturating count of applied resyncs (VTG_RESYNC_CNT_EN only)

module video_timing_gen #(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 12,
    parameter int H_SYNC   = 64,
    parameter int H_BP     = 68,
    parameter int V_ACTIVE = 576,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 39,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        vreset,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] hcnt,
    output logic [10:0] vcnt,
    output logic        frame_start
`ifdef VTG_RESYNC_CNT_EN
    ,
    output logic [7:0]  resync_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_DE_END = 12'(H_ACTIVE);
    localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_DE_END = 11'(V_ACTIVE);
    localparam logic [10:0] V_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    logic [11:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic        r_frame_start;
    logic        r_pend;

    logic        w_resync;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [11:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_de_next;
    logic        w_hs_act;
    logic        w_vs_act;

    // A request arriving in the same clk as ce is applied immediately, so the
    // pending flag only ever holds requests seen while ce was low.
    assign w_resync = r_pend | vreset;
    assign w_h_wrap = (r_hcnt == H_LAST);
    assign w_v_wrap = (r_vcnt == V_LAST);

    assign w_h_next = (w_resync || w_h_wrap) ? 12'd0 : r_hcnt + 12'd1;
    assign w_v_next = w_resync ? 11'd0 :
                      (w_h_wrap ? (w_v_wrap ? 11'd0 : r_vcnt + 11'd1) : r_vcnt);

    // Decoding the next counter values keeps the registered syncs/de aligned
    // with the counters presented in the same cycle.
    assign w_de_next = (w_h_next < H_DE_END) && (w_v_next < V_DE_END);
    assign w_hs_act  = (w_h_next >= H_HS_BEG) && (w_h_next < H_HS_END);
    assign w_vs_act  = (w_v_next >= V_VS_BEG) && (w_v_next < V_VS_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt        <= H_LAST;
            r_vcnt        <= V_LAST;
            r_hs          <= ~HS_ON;
            r_vs          <= ~VS_ON;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_pend        <= 1'b0;
        end else if (ce) begin
            r_hcnt        <= w_h_next;
            r_vcnt        <= w_v_next;
            r_hs          <= w_hs_act ? HS_ON : ~HS_ON;
            r_vs          <= w_vs_act ? VS_ON : ~VS_ON;
            r_de          <= w_de_next;
            r_frame_start <= (w_h_next == 12'd0) && (w_v_next == 11'd0);
            r_pend        <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (vreset) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign frame_start = r_frame_start;

`ifdef VTG_RESYNC_CNT_EN
    logic [7:0] r_resync_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resync_cnt <= 8'd0;
        end else if (ce && w_resync && (r_resync_cnt != 8'hFF)) begin
            r_resync_cnt <= r_resync_cnt + 8'd1;
        end
    end

    assign resync_cnt = r_resync_cnt;
`endif

endmodule
